// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one iterative fp_div (start/done handshake) among N_REQ requesters.
// Define FP_DIV_SCHED_STATS_EN to enable the per-requester saturating grant counters on stat_grants.
module fp_div_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_op_a,
  output logic [DATA_W-1:0]         div_op_b,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_res,
  output logic [N_REQ*16-1:0]       stat_grants
);

  localparam int GW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              found_s;
  logic [GW-1:0]     pick_s;
  logic              accept_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    logic [GW-1:0] idx_v;
    found_s = 1'b0;
    pick_s  = '0;
    idx_v   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v   = GW'((int'(ptr_q) + k) % N_REQ);
      pick_s  = (!found_s && req_valid[idx_v]) ? idx_v : pick_s;
      found_s = found_s | req_valid[idx_v];
    end
  end

  // Next-state and datapath update; run overrides everything except rst.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    accept_s = 1'b0;
    if (run) begin
      state_d = S_IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_s) begin
            accept_s = 1'b1;
            gnt_d    = pick_s;
            op_a_d   = req_a[int'(pick_s)*DATA_W +: DATA_W];
            op_b_d   = req_b[int'(pick_s)*DATA_W +: DATA_W];
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          wdog_d = wdog_q + WDW'(1);
          // A completion on the very last watchdog cycle still delivers the real result.
          if (div_done) begin
            res_d   = div_res;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_RESP: begin
          if (resp_ready[gnt_q]) begin
            ptr_d   = (gnt_q == GW'(N_REQ - 1)) ? '0 : gnt_q + GW'(1);
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  // req_ready is the same-cycle accept; masked by rst so reset forces it low immediately.
  assign req_ready  = (accept_s && !rst) ? onehot(pick_s) : '0;
  assign resp_valid = (state_q == S_RESP && !run) ? onehot(gnt_q) : '0;
  assign resp_data  = res_q;
  assign resp_err   = err_q;
  assign div_start  = (state_q == S_START);
  assign div_op_a   = op_a_q;
  assign div_op_b   = op_b_q;

`ifdef FP_DIV_SCHED_STATS_EN
  logic [N_REQ*16-1:0] stat_q, stat_d;

  // Saturating per-requester grant counts.
  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (accept_s && pick_s == GW'(k) && stat_q[k*16 +: 16] != 16'hFFFF) begin
        stat_d[k*16 +: 16] = stat_q[k*16 +: 16] + 16'd1;
      end else begin
        stat_d[k*16 +: 16] = stat_q[k*16 +: 16];
      end
    end
  end

  // Counters survive run; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_grants = stat_q;
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_fp_div_sched.sv
// Randomized self-checking bench for fp_div_sched with a behavioural divider and scheduler model.
module tb_fp_div_sched;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst, run;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     resp_data, div_op_a, div_op_b, div_res;
  logic             resp_err, div_start, div_done;
  logic [N*16-1:0]  stat_grants;
  logic             mdl_done, force_done;

  fp_div_sched #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_done(div_done), .div_res(div_res), .stat_grants(stat_grants)
  );

  always #5 clk = ~clk;
  assign div_done = mdl_done | force_done;

  int vec_cnt = 0;
  int miscompare_cnt = 0;
  int ptr_m = 0;
  int grants_m [N];
  int div_lat = 5;
  bit div_hang = 1'b0;
  int div_cnt;
  bit div_busy;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h3FC00000;
    return a ^ {b[7:0], b[31:8]} ^ 32'h5A5A0001;
  endfunction

  // Iterative divider stand-in: done pulses div_lat cycles after the start cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_done <= 1'b0; div_busy <= 1'b0; div_cnt <= 0; div_res <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (run) begin
        div_busy <= 1'b0;
      end else if (div_start && !div_hang) begin
        if (div_lat == 1) begin
          mdl_done <= 1'b1; div_res <= div_fn(div_op_a, div_op_b);
        end else begin
          div_busy <= 1'b1; div_cnt <= div_lat - 1;
        end
      end else if (div_busy) begin
        div_cnt <= div_cnt - 1;
        if (div_cnt == 1) begin
          div_busy <= 1'b0; mdl_done <= 1'b1; div_res <= div_fn(div_op_a, div_op_b);
        end
      end
    end
  end

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic check_stats(input string tag);
    for (int i = 0; i < N; i++) begin
`ifdef FP_DIV_SCHED_STATS_EN
      check_eq(tag, stat_grants[i*16 +: 16], grants_m[i]);
`else
      check_eq(tag, stat_grants[i*16 +: 16], 0);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One complete transaction from IDLE back to IDLE; g returns the grant the model predicted.
  task automatic do_op(input logic [N-1:0] v, input int lat, input int bp, input bit hang,
                       input bit other_ready, input logic [31:0] ain, input logic [31:0] bin,
                       output int g);
    logic [31:0] exp_d;
    int c;
    g = exp_grant(v);
    div_lat = lat;
    div_hang = hang;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
    req_a[g*W +: W] = ain;
    req_b[g*W +: W] = bin;
    req_valid = v;
    #1;
    check_eq("accept", req_ready, 1 << g);
    grants_m[g] = (grants_m[g] < 65535) ? grants_m[g] + 1 : 65535;
    exp_d = hang ? 32'h0 : div_fn(ain, bin);
    step();
    req_valid = N'($urandom);
    #1;
    check_eq("div_start", div_start, 1);
    check_eq("op_a", div_op_a, ain);
    check_eq("op_b", div_op_b, bin);
    check_eq("busy_rdy", req_ready, 0);
    c = 1;
    while (resp_valid === '0 && c < 300) begin
      step();
      c++;
      check_eq("wait_rdy", req_ready, 0);
      if (c == 2) check_eq("start_pulse", div_start, 0);
    end
    check_eq("latency", c, hang ? 2 + TO : 2 + lat);
    check_eq("resp_valid", resp_valid, 1 << g);
    check_eq("resp_data", resp_data, exp_d);
    check_eq("resp_err", resp_err, hang);
    resp_ready = other_ready ? ~(N'(1) << g) : '0;
    req_valid = '1;
    for (int k = 0; k < bp; k++) begin
      force_done = hang && (k == 0);
      #1;
      check_eq("bp_valid", resp_valid, 1 << g);
      check_eq("bp_data", resp_data, exp_d);
      check_eq("bp_err", resp_err, hang);
      check_eq("bp_rdy", req_ready, 0);
      step();
    end
    force_done = 1'b0;
    resp_ready[g] = 1'b1;
    #1;
    check_eq("hs_rdy", req_ready, 0);
    step();
    resp_ready = '0;
    req_valid = '0;
    #1;
    check_eq("resp_drop", resp_valid, 0);
    ptr_m = (g + 1) % N;
  endtask

  initial begin
    int g;
    #200_000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int g;
    rst = 1'b1; run = 1'b0; req_valid = '0; resp_ready = '0;
    req_a = '0; req_b = '0; force_done = 1'b0;
    for (int i = 0; i < N; i++) grants_m[i] = 0;
    step();
    req_valid = 4'b1111;
    #1;
    check_eq("rst_rdy", req_ready, 0);
    check_eq("rst_valid", resp_valid, 0);
    check_eq("rst_start", div_start, 0);
    check_eq("rst_opa", div_op_a, 0);
    check_eq("rst_data", resp_data, 0);
    check_eq("rst_err", resp_err, 0);
    check_stats("rst_stats");
    req_valid = '0;
    step();
    rst = 1'b0;
    step();

    // Fairness: all requesters always valid
    for (int i = 0; i < 8; i++) begin
      do_op(4'b1111, 3, 0, 1'b0, 1'b0, $urandom, $urandom, g);
      check_eq("rr_order", g, i % 4);
    end
    for (int i = 0; i < N; i++) check_eq("rr_count", grants_m[i], 2);
    check_stats("rr_stats");

    // Single 3.0/2.0 with 50-cycle divider
    do_op(4'b0001, 50, 0, 1'b0, 1'b0, 32'h40400000, 32'h40000000, g);
    check_eq("t1_grant", g, 0);

    // Backpressure with other requesters' resp_ready high
    do_op(4'b0110, 7, 20, 1'b0, 1'b1, $urandom, $urandom, g);

    // Timeout with stale done in RESP, then in IDLE
    do_op(4'b1000, 1, 3, 1'b1, 1'b0, $urandom, $urandom, g);
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    #1;
    check_eq("stale_valid", resp_valid, 0);
    check_eq("stale_start", div_start, 0);
    step();
    check_eq("stale_valid2", resp_valid, 0);

    // Abort: run beats a request in IDLE, then kills an op in WAIT
    do_op(4'b0100, 2, 0, 1'b0, 1'b0, $urandom, $urandom, g);
    req_valid = 4'b1111; run = 1'b1;
    #1;
    check_eq("run_idle_rdy", req_ready, 0);
    step();
    run = 1'b0;
    ptr_m = 0;
    do_op(4'b1000, 2, 0, 1'b0, 1'b0, $urandom, $urandom, g);
    div_lat = 20; div_hang = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_eq("abort_accept", req_ready, 1 << exp_grant(4'b1111));
    grants_m[exp_grant(4'b1111)]++;
    step();
    req_valid = '0;
    step(); step(); step();
    run = 1'b1;
    #1;
    check_eq("abort_valid", resp_valid, 0);
    step();
    run = 1'b0;
    ptr_m = 0;
    for (int k = 0; k < 25; k++) begin
      #1;
      check_eq("abort_quiet", resp_valid, 0);
      check_eq("abort_start", div_start, 0);
      step();
    end
    do_op(4'b1111, 4, 0, 1'b0, 1'b0, $urandom, $urandom, g);
    check_eq("abort_next", g, 0);
    check_stats("abort_stats");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      do_op(N'($urandom_range(1, 15)), $urandom_range(1, 12), $urandom_range(0, 4), 1'b0,
            1'($urandom), $urandom, $urandom, g);
    end
    check_stats("rand_stats");

    // Asynchronous reset mid-WAIT
    div_lat = 30; div_hang = 1'b0;
    req_valid = 4'b0010; req_a[W +: W] = 32'h12345678;
    #1;
    check_eq("t6_accept", req_ready, 4'b0010);
    step();
    req_valid = 4'b1111;
    step(); step();
    rst = 1'b1;
    #1;
    check_eq("t6_rdy", req_ready, 0);
    check_eq("t6_valid", resp_valid, 0);
    check_eq("t6_start", div_start, 0);
    check_eq("t6_opa", div_op_a, 0);
    check_eq("t6_opb", div_op_b, 0);
    check_eq("t6_data", resp_data, 0);
    check_eq("t6_err", resp_err, 0);
    for (int i = 0; i < N; i++) grants_m[i] = 0;
    check_stats("t6_stats");
    req_valid = '0;
    step();
    rst = 1'b0;
    ptr_m = 0;
    step();
    do_op(4'b1010, 6, 1, 1'b0, 1'b0, $urandom, $urandom, g);
    check_eq("t6_grant", g, 1);
    check_stats("t6_stats2");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end
endmodule
